// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: runs a batch of 2**NAVG_LOG2 TDC start/stop measurements,
// averages the {coarse,fine} samples and ships a framed result byte-wise to a
// UART transmitter over a valid/ready handshake, pulsing eot when done.
module tdc_meas_sequencer #(
  parameter int CNT_W     = 16,
  parameter int FINE_W    = 5,
  parameter int NAVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              stop,
  input  logic [FINE_W-1:0] fine_code,
  input  logic              fine_valid,
  output logic              start_pulse,
  output logic              tdc_arm,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              eot,
  output logic              timeout_err
);

  localparam int S_W    = CNT_W + FINE_W;
  localparam int ACC_W  = S_W + NAVG_LOG2;
  localparam int NB     = (S_W + 7) / 8;
  localparam int PAD_W  = NB * 8;
  localparam int BIDX_W = $clog2(NB + 2);
  localparam int MEAS_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;

  // Frame is header, NB result bytes, then one status byte.
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NB + 1);
  localparam logic [MEAS_W-1:0] MEAS_LAST = MEAS_W'((1 << NAVG_LOG2) - 1);
  localparam logic [3:0]        FINE_TO   = 4'd15;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_STOP = 3'd2;
  localparam logic [2:0] WAIT_FINE = 3'd3;
  localparam logic [2:0] ACCUM     = 3'd4;
  localparam logic [2:0] SEND      = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]        state;
  logic [CNT_W-1:0]  coarse;
  logic [FINE_W-1:0] fine;
  logic [3:0]        fine_wait;
  logic [ACC_W-1:0]  acc;
  logic [MEAS_W-1:0] meas_idx;
  logic [BIDX_W-1:0] byte_idx;
  logic [PAD_W-1:0]  result_pad;

  // Average is the accumulator with the low NAVG_LOG2 bits dropped, zero-padded to whole bytes.
  assign result_pad = PAD_W'(acc[ACC_W-1:NAVG_LOG2]);

  // Sequencer: measurement loop, timeouts, accumulation and byte-wise frame transmission.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      coarse      <= '0;
      fine        <= '0;
      fine_wait   <= '0;
      acc         <= '0;
      meas_idx    <= '0;
      byte_idx    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            acc         <= '0;
            meas_idx    <= '0;
            timeout_err <= 1'b0;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          coarse <= '0;
          state  <= WAIT_STOP;
        end
        WAIT_STOP: begin
          if (stop) begin
            fine_wait <= '0;
            state     <= WAIT_FINE;
          end else if (coarse == '1) begin
            fine        <= '0;
            timeout_err <= 1'b1;
            state       <= ACCUM;
          end else begin
            coarse <= coarse + CNT_W'(1);
          end
        end
        WAIT_FINE: begin
          if (fine_valid) begin
            fine  <= fine_code;
            state <= ACCUM;
          end else if (fine_wait == FINE_TO) begin
            fine        <= '0;
            timeout_err <= 1'b1;
            state       <= ACCUM;
          end else begin
            fine_wait <= fine_wait + 4'd1;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'({coarse, fine});
          if (meas_idx == MEAS_LAST) begin
            byte_idx <= '0;
            state    <= SEND;
          end else begin
            meas_idx <= meas_idx + MEAS_W'(1);
            state    <= LAUNCH;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_idx == LAST_BYTE) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + BIDX_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte selection for the frame currently being sent; zero whenever not sending.
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      if (byte_idx == '0) begin
        tx_data = 8'hA5;
      end else if (byte_idx == LAST_BYTE) begin
        tx_data = {7'b0, timeout_err};
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (byte_idx == BIDX_W'(i + 1)) begin
            tx_data = result_pad[PAD_W-8-8*i +: 8];
          end
        end
      end
    end
  end

  assign start_pulse = (state == LAUNCH);
  assign tdc_arm     = (state == WAIT_STOP);
  assign tx_valid    = (state == SEND);
  assign busy        = (state != IDLE);
  assign eot         = (state == DONE);

endmodule
